// File: rtl/instr_assembler_pkg.sv
// Shared instruction-set definitions for the assembler and its encoder.
package instr_assembler_pkg;

  typedef enum logic [5:0] {
    OpRtype = 6'h00,
    OpJ     = 6'h02,
    OpBeq   = 6'h04,
    OpAddi  = 6'h08,
    OpLw    = 6'h23,
    OpSw    = 6'h2B
  } OpCode;

  typedef enum logic [5:0] {
    FnAdd = 6'h20,
    FnSub = 6'h22,
    FnAnd = 6'h24,
    FnOr  = 6'h25
  } Funct;

  typedef logic [31:0] Instruction;
  typedef logic [7:0]  ProgramCounter;

  typedef struct packed {
    OpCode      opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    Funct       funct;
  } RType;

  typedef struct packed {
    OpCode       opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
  } IType;

  typedef struct packed {
    OpCode       opcode;
    logic [25:0] jaddr;
  } JType;

endpackage

// File: rtl/instr_encoder.sv
// Combinational field-to-word encoder; illegal encodings yield a zero word.
module instr_encoder
  import instr_assembler_pkg::*;
(
  input  OpCode       opcode_i,
  input  Funct        funct_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] jaddr_i,
  output Instruction  word_o,
  output logic        illegal_o
);

  RType r_word;
  IType i_word;
  JType j_word;

  assign r_word = '{opcode: opcode_i, rs: rs_i, rt: rt_i, rd: rd_i, shamt: shamt_i,
                    funct: funct_i};
  assign i_word = '{opcode: opcode_i, rs: rs_i, rt: rt_i, imm: imm_i};
  assign j_word = '{opcode: opcode_i, jaddr: jaddr_i};

  // Select the format by opcode; unknown opcodes or R-type functs are illegal.
  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (opcode_i)
      OpRtype: begin
        case (funct_i)
          FnAdd, FnSub, FnAnd, FnOr: word_o = r_word;
          default:                   illegal_o = 1'b1;
        endcase
      end
      OpAddi, OpBeq, OpLw, OpSw: word_o = i_word;
      OpJ:                       word_o = j_word;
      default:                   illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_assembler.sv
// Accepts instruction field requests, encodes them and writes one word per
// transfer into instruction memory at consecutive addresses.
module instr_assembler
  import instr_assembler_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  ProgramCounter base_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  OpCode         in_opcode,
  input  Funct          in_funct,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_shamt,
  input  logic [15:0]   in_imm,
  input  logic [25:0]   in_jaddr,
  input  logic          in_last,
  output logic          mem_we,
  output ProgramCounter mem_addr,
  output Instruction    mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          full,
  output logic [8:0]    count
);

  localparam logic [8:0] MaxWords = 9'(MEM_WORDS);

  typedef enum logic [1:0] {StIdle, StAccept, StWrite, StDone} state_e;

  state_e        state_q, state_d;
  ProgramCounter addr_q;
  logic          last_q;
  logic [8:0]    count_q;
  logic [8:0]    count_inc;
  logic          err_q, full_q;
  logic          xfer;
  Instruction    enc_word;
  logic          enc_illegal;

  assign xfer      = (state_q == StAccept) && in_valid;
  assign count_inc = count_q + 9'd1;
  assign count     = count_q;
  assign err       = err_q;
  assign full      = full_q;

  instr_encoder u_encoder (
    .opcode_i  (in_opcode),
    .funct_i   (in_funct),
    .rs_i      (in_rs),
    .rt_i      (in_rt),
    .rd_i      (in_rd),
    .shamt_i   (in_shamt),
    .imm_i     (in_imm),
    .jaddr_i   (in_jaddr),
    .word_o    (enc_word),
    .illegal_o (enc_illegal)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state and handshake/status outputs.
  always_comb begin
    state_d  = state_q;
    mem_we   = 1'b0;
    in_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) state_d = StAccept;
      end
      StAccept: begin
        in_ready = 1'b1;
        if (in_valid) state_d = StWrite;
      end
      StWrite: begin
        mem_we  = 1'b1;
        state_d = (last_q || count_inc == MaxWords) ? StDone : StAccept;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Session datapath: address, captured word, counters and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      last_q    <= 1'b0;
      count_q   <= '0;
      err_q     <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      if (state_q == StIdle && start) begin
        addr_q  <= base_addr;
        count_q <= '0;
        err_q   <= 1'b0;
        full_q  <= 1'b0;
      end
      if (xfer) begin
        mem_addr  <= addr_q;
        mem_wdata <= enc_word;
        last_q    <= in_last;
        if (enc_illegal) err_q <= 1'b1;
      end
      if (state_q == StWrite) begin
        addr_q  <= addr_q + 8'd1;
        count_q <= count_inc;
        // Running out of room only counts as full when the session was not ending anyway.
        if (!last_q && count_inc == MaxWords) full_q <= 1'b1;
      end
    end
  end

endmodule
